writeback_arbiter: RTL and testbench

- Initiator side of the register file's single write port: accepts write requests from the ALU stage and the memory stage and serialises them onto one registered write port (`writeRegister`/`writeData`/`regWrite`).
- The ALU source is a direct, one-deep path; the memory source is buffered in a small FIFO.
- Also supplies same-cycle forwarding for the in-flight write and hazard flags for queued writes, so the decode stage can read consistent operands.

---
 rtl/writeback_arbiter_if.sv | 48 ++++
 rtl/writeback_arbiter.sv | 174 +++++++++++++++++
 tb/tb_writeback_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
// Handshake and register-file bus bundle for writeback_arbiter.
// slave is the arbiter's view; master is the surrounding pipeline's view.
interface writeback_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  aluValid;
    logic                  aluReady;
    logic [ADDR_WIDTH-1:0] aluRegister;
    logic [DATA_WIDTH-1:0] aluData;

    logic                  memValid;
    logic                  memReady;
    logic [ADDR_WIDTH-1:0] memRegister;
    logic [DATA_WIDTH-1:0] memData;

    logic [ADDR_WIDTH-1:0] writeRegister;
    logic [DATA_WIDTH-1:0] writeData;
    logic                  regWrite;

    logic [ADDR_WIDTH-1:0] readRegister1;
    logic [ADDR_WIDTH-1:0] readRegister2;
    logic [DATA_WIDTH-1:0] readData1;
    logic [DATA_WIDTH-1:0] readData2;
    logic [DATA_WIDTH-1:0] fwdData1;
    logic [DATA_WIDTH-1:0] fwdData2;
    logic                  hazard1;
    logic                  hazard2;
    logic                  busy;

    modport slave (
        input  aluValid, aluRegister, aluData,
        input  memValid, memRegister, memData,
        input  readRegister1, readRegister2, readData1, readData2,
        output aluReady, memReady,
        output writeRegister, writeData, regWrite,
        output fwdData1, fwdData2, hazard1, hazard2, busy
    );

    modport master (
        output aluValid, aluRegister, aluData,
        output memValid, memRegister, memData,
        output readRegister1, readRegister2, readData1, readData2,
        input  aluReady, memReady,
        input  writeRegister, writeData, regWrite,
        input  fwdData1, fwdData2, hazard1, hazard2, busy
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Serialises ALU and buffered memory-stage writes onto one registered register-file write port.
// Define WB_STATS_EN to add saturating writeCount/stallCount statistics outputs.
module writeback_arbiter #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic clk,
    input  logic resetN,
    writeback_arbiter_if.slave bus
`ifdef WB_STATS_EN
    ,
    output logic [15:0] writeCount,
    output logic [15:0] stallCount
`endif
);
    localparam int unsigned PtrW    = $clog2(DEPTH);
    localparam int unsigned CntW    = PtrW + 1;
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [0:0] {StNormal, StDrain} arbStateT;

    arbStateT stateQ, stateD;

    logic [ADDR_WIDTH-1:0] fifoReg  [DEPTH];
    logic [DATA_WIDTH-1:0] fifoData [DEPTH];
    logic [PtrW-1:0]       wrPtrQ, rdPtrQ;
    logic [CntW-1:0]       countQ;
    logic [StarveW-1:0]    starveQ, starveD;

    logic                  empty, full, push, pop, issueAlu, issue, aluReadyInt;
    logic [ADDR_WIDTH-1:0] issueReg;
    logic [DATA_WIDTH-1:0] issueData;

    logic [ADDR_WIDTH-1:0] writeRegQ;
    logic [DATA_WIDTH-1:0] writeDataQ;
    logic                  regWriteQ;

    logic [PtrW-1:0]       entryOff   [DEPTH];
    logic [DEPTH-1:0]      entryValid;

    assign empty = (countQ == '0);
    assign full  = (countQ == CntW'(DEPTH));
    assign push  = bus.memValid && !full;

    always_comb begin
        stateD      = stateQ;
        aluReadyInt = 1'b0;
        issueAlu    = 1'b0;
        pop         = 1'b0;
        starveD     = starveQ;
        case (stateQ)
            StNormal: begin
                aluReadyInt = 1'b1;
                if (bus.aluValid) begin
                    issueAlu = 1'b1;
                end else if (!empty) begin
                    pop = 1'b1;
                end
                if (empty || pop) begin
                    starveD = '0;
                end else begin
                    starveD = StarveW'(starveQ + 1'b1);
                end
                if (starveD == StarveW'(STARVE_LIMIT)) begin
                    stateD = StDrain;
                end
            end
            StDrain: begin
                pop     = !empty;
                starveD = '0;
                stateD  = StNormal;
            end
            default: stateD = StNormal;
        endcase
    end

    assign issue     = issueAlu || pop;
    assign issueReg  = issueAlu ? bus.aluRegister : fifoReg[rdPtrQ];
    assign issueData = issueAlu ? bus.aluData : fifoData[rdPtrQ];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stateQ  <= StNormal;
            starveQ <= '0;
            wrPtrQ  <= '0;
            rdPtrQ  <= '0;
            countQ  <= '0;
        end else begin
            stateQ  <= stateD;
            starveQ <= starveD;
            if (push) wrPtrQ <= PtrW'(wrPtrQ + 1'b1);
            if (pop)  rdPtrQ <= PtrW'(rdPtrQ + 1'b1);
            if (push && !pop) begin
                countQ <= CntW'(countQ + 1'b1);
            end else if (pop && !push) begin
                countQ <= CntW'(countQ - 1'b1);
            end
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoReg[wrPtrQ]  <= bus.memRegister;
            fifoData[wrPtrQ] <= bus.memData;
        end
    end

    // Register 0 is consumed like any other issue but never written.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            writeRegQ  <= '0;
            writeDataQ <= '0;
            regWriteQ  <= 1'b0;
        end else begin
            regWriteQ <= issue && (issueReg != '0);
            if (issue) begin
                writeRegQ  <= issueReg;
                writeDataQ <= issueData;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entryOff[i]   = PtrW'(PtrW'(i) - rdPtrQ);
            entryValid[i] = ({1'b0, entryOff[i]} < countQ);
        end
    end

    always_comb begin
        bus.hazard1 = 1'b0;
        bus.hazard2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryValid[i] && fifoReg[i] == bus.readRegister1 && bus.readRegister1 != '0) begin
                bus.hazard1 = 1'b1;
            end
            if (entryValid[i] && fifoReg[i] == bus.readRegister2 && bus.readRegister2 != '0) begin
                bus.hazard2 = 1'b1;
            end
        end
    end

    assign bus.fwdData1 = (regWriteQ && writeRegQ == bus.readRegister1 && bus.readRegister1 != '0)
                          ? writeDataQ : bus.readData1;
    assign bus.fwdData2 = (regWriteQ && writeRegQ == bus.readRegister2 && bus.readRegister2 != '0)
                          ? writeDataQ : bus.readData2;

    assign bus.aluReady      = aluReadyInt;
    assign bus.memReady      = !full;
    assign bus.writeRegister = writeRegQ;
    assign bus.writeData     = writeDataQ;
    assign bus.regWrite      = regWriteQ;
    assign bus.busy          = !empty || regWriteQ;

`ifdef WB_STATS_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            writeCount <= '0;
            stallCount <= '0;
        end else begin
            if (regWriteQ && writeCount != 16'hFFFF) begin
                writeCount <= writeCount + 16'd1;
            end
            if (((bus.aluValid && !aluReadyInt) || (bus.memValid && full))
                && stallCount != 16'hFFFF) begin
                stallCount <= stallCount + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed vector bench for writeback_arbiter: per-cycle stimulus/expectation table
// followed by a hand-written reset-while-busy sequence.
module tb_writeback_arbiter;
    localparam logic [31:0] D1 = 32'h0000_1111;
    localparam logic [31:0] D2 = 32'h0000_2222;

    typedef struct {
        logic        aV;
        logic [4:0]  aR;
        logic [31:0] aD;
        logic        mV;
        logic [4:0]  mR;
        logic [31:0] mD;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] rd1;
        logic        eAluRdy;
        logic        eMemRdy;
        logic        eRw;
        logic [4:0]  eWr;
        logic [31:0] eWd;
        logic [31:0] eF1;
        logic [31:0] eF2;
        logic        eH1;
        logic        eH2;
        logic        eBusy;
    } vecT;

    logic clk;
    logic resetN;
    int   nVec;
    int   nMis;
    vecT  vecs[$];

    writeback_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

`ifdef WB_STATS_EN
    logic [15:0] writeCount;
    logic [15:0] stallCount;
`endif

    writeback_arbiter #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (5),
        .DEPTH       (4),
        .STARVE_LIMIT(3)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
`ifdef WB_STATS_EN
        ,
        .writeCount(writeCount),
        .stallCount(stallCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        if (act !== exp) begin
            nMis++;
            $display("FAIL vec%0d %s: got %h, expected %h", idx, nm, act, exp);
        end
    endtask

    task automatic addVec(input logic aV, input logic [4:0] aR, input logic [31:0] aD,
                          input logic mV, input logic [4:0] mR, input logic [31:0] mD,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [31:0] rd1,
                          input logic eAR, input logic eMR, input logic eRw,
                          input logic [4:0] eWr, input logic [31:0] eWd,
                          input logic [31:0] eF1, input logic [31:0] eF2,
                          input logic eH1, input logic eH2, input logic eB);
        vecT v;
        v.aV = aV; v.aR = aR; v.aD = aD; v.mV = mV; v.mR = mR; v.mD = mD;
        v.r1 = r1; v.r2 = r2; v.rd1 = rd1;
        v.eAluRdy = eAR; v.eMemRdy = eMR; v.eRw = eRw; v.eWr = eWr; v.eWd = eWd;
        v.eF1 = eF1; v.eF2 = eF2; v.eH1 = eH1; v.eH2 = eH2; v.eBusy = eB;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic aV, input logic [4:0] aR, input logic [31:0] aD,
                         input logic mV, input logic [4:0] mR, input logic [31:0] mD,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [31:0] rd1);
        bus.aluValid = aV; bus.aluRegister = aR; bus.aluData = aD;
        bus.memValid = mV; bus.memRegister = mR; bus.memData = mD;
        bus.readRegister1 = r1; bus.readRegister2 = r2;
        bus.readData1 = rd1; bus.readData2 = D2;
    endtask

    initial begin
        nVec = 0;
        nMis = 0;

        // ALU single write and its one-cycle latency
        addVec(0, 0, 0, 0, 0, 0, 31, 30, D1, 1, 1, 0, 0, 0, D1, D2, 0, 0, 0);
        addVec(1, 5, 32'hDEADBEEF, 0, 0, 0, 31, 30, D1, 1, 1, 0, 0, 0, D1, D2, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 31, 30, D1, 1, 1, 1, 5, 32'hDEADBEEF, D1, D2, 0, 0, 1);
        addVec(0, 0, 0, 0, 0, 0, 31, 30, D1, 1, 1, 0, 0, 0, D1, D2, 0, 0, 0);
        // Fill the FIFO while the ALU issues to reg 0, then drain in order
        addVec(1, 0, 0, 1, 1, 32'h11, 31, 30, D1, 1, 1, 0, 0, 0, D1, D2, 0, 0, 0);
        addVec(1, 0, 0, 1, 2, 32'h22, 31, 30, D1, 1, 1, 0, 0, 0, D1, D2, 0, 0, 1);
        addVec(1, 0, 0, 1, 3, 32'h33, 31, 30, D1, 1, 1, 0, 0, 0, D1, D2, 0, 0, 1);
        addVec(1, 0, 0, 1, 4, 32'h44, 31, 30, D1, 1, 1, 0, 0, 0, D1, D2, 0, 0, 1);
        addVec(0, 0, 0, 0, 0, 0, 3, 30, D1, 0, 0, 0, 0, 0, D1, D2, 1, 0, 1);
        addVec(0, 0, 0, 0, 0, 0, 1, 30, D1, 1, 1, 1, 1, 32'h11, 32'h11, D2, 0, 0, 1);
        addVec(0, 0, 0, 0, 0, 0, 31, 30, D1, 1, 1, 1, 2, 32'h22, D1, D2, 0, 0, 1);
        addVec(0, 0, 0, 0, 0, 0, 31, 30, D1, 1, 1, 1, 3, 32'h33, D1, D2, 0, 0, 1);
        addVec(0, 0, 0, 0, 0, 0, 31, 30, D1, 1, 1, 1, 4, 32'h44, D1, D2, 0, 0, 1);
        addVec(0, 0, 0, 0, 0, 0, 31, 30, D1, 1, 1, 0, 0, 0, D1, D2, 0, 0, 0);
        // Starvation: reg 7 waits three ALU issues, then takes one DRAIN cycle
        addVec(0, 0, 0, 1, 7, 32'h77, 31, 30, D1, 1, 1, 0, 0, 0, D1, D2, 0, 0, 0);
        addVec(1, 10, 32'hA1, 0, 0, 0, 31, 30, D1, 1, 1, 0, 0, 0, D1, D2, 0, 0, 1);
        addVec(1, 11, 32'hA2, 0, 0, 0, 31, 30, D1, 1, 1, 1, 10, 32'hA1, D1, D2, 0, 0, 1);
        addVec(1, 12, 32'hA3, 0, 0, 0, 31, 30, D1, 1, 1, 1, 11, 32'hA2, D1, D2, 0, 0, 1);
        addVec(1, 13, 32'hA4, 0, 0, 0, 7, 30, D1, 0, 1, 1, 12, 32'hA3, D1, D2, 1, 0, 1);
        addVec(1, 13, 32'hA4, 0, 0, 0, 7, 30, D1, 1, 1, 1, 7, 32'h77, 32'h77, D2, 0, 0, 1);
        addVec(0, 0, 0, 0, 0, 0, 31, 30, D1, 1, 1, 1, 13, 32'hA4, D1, D2, 0, 0, 1);
        addVec(0, 0, 0, 0, 0, 0, 31, 30, D1, 1, 1, 0, 0, 0, D1, D2, 0, 0, 0);
        // Forwarding of the in-flight write
        addVec(1, 9, 32'hCAFE0000, 0, 0, 0, 9, 30, 0, 1, 1, 0, 0, 0, 0, D2, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 9, 9, 0, 1, 1, 1, 9, 32'hCAFE0000,
               32'hCAFE0000, 32'hCAFE0000, 0, 0, 1);
        addVec(0, 0, 0, 0, 0, 0, 9, 30, 0, 1, 1, 0, 0, 0, 0, D2, 0, 0, 0);
        // Hazard on a queued entry, plus a reg-0 ALU issue that writes nothing
        addVec(1, 20, 32'hB0, 1, 12, 32'hC, 31, 12, D1, 1, 1, 0, 0, 0, D1, D2, 0, 0, 0);
        addVec(1, 21, 32'hB1, 0, 0, 0, 31, 12, D1, 1, 1, 1, 20, 32'hB0, D1, D2, 0, 1, 1);
        addVec(1, 0, 32'hFF, 0, 0, 0, 31, 12, D1, 1, 1, 1, 21, 32'hB1, D1, D2, 0, 1, 1);
        addVec(1, 22, 32'hB2, 0, 0, 0, 31, 12, D1, 1, 1, 0, 0, 0, D1, D2, 0, 1, 1);
        addVec(0, 0, 0, 0, 0, 0, 31, 12, D1, 0, 1, 1, 22, 32'hB2, D1, D2, 0, 1, 1);
        addVec(0, 0, 0, 0, 0, 0, 31, 12, D1, 1, 1, 1, 12, 32'hC, D1, 32'hC, 0, 0, 1);
        addVec(0, 0, 0, 0, 0, 0, 31, 12, D1, 1, 1, 0, 0, 0, D1, D2, 0, 0, 0);

        drive(0, 0, 0, 0, 0, 0, 31, 30, D1);
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nVec++;
        check("rst.regWrite", -1, 32'(bus.regWrite), 0);
        check("rst.writeRegister", -1, 32'(bus.writeRegister), 0);
        check("rst.writeData", -1, bus.writeData, 0);
        check("rst.memReady", -1, 32'(bus.memReady), 1);
        check("rst.aluReady", -1, 32'(bus.aluReady), 1);
        check("rst.busy", -1, 32'(bus.busy), 0);
        #1 resetN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].aV, vecs[i].aR, vecs[i].aD, vecs[i].mV, vecs[i].mR, vecs[i].mD,
                  vecs[i].r1, vecs[i].r2, vecs[i].rd1);
            @(negedge clk);
            nVec++;
            check("aluReady", i, 32'(bus.aluReady), 32'(vecs[i].eAluRdy));
            check("memReady", i, 32'(bus.memReady), 32'(vecs[i].eMemRdy));
            check("regWrite", i, 32'(bus.regWrite), 32'(vecs[i].eRw));
            if (vecs[i].eRw) begin
                check("writeRegister", i, 32'(bus.writeRegister), 32'(vecs[i].eWr));
                check("writeData", i, bus.writeData, vecs[i].eWd);
            end
            check("fwdData1", i, bus.fwdData1, vecs[i].eF1);
            check("fwdData2", i, bus.fwdData2, vecs[i].eF2);
            check("hazard1", i, 32'(bus.hazard1), 32'(vecs[i].eH1));
            check("hazard2", i, 32'(bus.hazard2), 32'(vecs[i].eH2));
            check("busy", i, 32'(bus.busy), 32'(vecs[i].eBusy));
        end

        // Reset with three entries queued and a write in flight
        @(posedge clk); #1 drive(1, 0, 0, 1, 3, 32'h301, 31, 30, D1);
        @(posedge clk); #1 drive(1, 0, 0, 1, 5, 32'h501, 31, 30, D1);
        @(posedge clk); #1 drive(1, 8, 32'h801, 1, 6, 32'h601, 31, 30, D1);
        @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 5, 30, D1);
        @(negedge clk);
        nVec++;
        check("pre.hazard1", 100, 32'(bus.hazard1), 1);
        check("pre.regWrite", 100, 32'(bus.regWrite), 1);
        check("pre.memReady", 100, 32'(bus.memReady), 1);
        #2 resetN = 1'b0;
        #1;
        nVec++;
        check("mid.busy", 101, 32'(bus.busy), 0);
        check("mid.regWrite", 101, 32'(bus.regWrite), 0);
        check("mid.memReady", 101, 32'(bus.memReady), 1);
        check("mid.hazard1", 101, 32'(bus.hazard1), 0);
        @(negedge clk);
        #1 resetN = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            nVec++;
            check("post.regWrite", 102 + c, 32'(bus.regWrite), 0);
            check("post.busy", 102 + c, 32'(bus.busy), 0);
            check("post.hazard1", 102 + c, 32'(bus.hazard1), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule
